// File: rtl/bandai2003_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : bandai2003_pkg                                                 |
// | Purpose : Shared constants for the cartridge serial-EEPROM controller:   |
// |           I/O port map, Microwire opcodes, command/status bit positions, |
// |           frame FSM states and the command priority decoder.             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package bandai2003_pkg;

  // Console I/O ports decoded by the controller
  localparam logic [7:0] PORT_DATA_LO = 8'hC4;
  localparam logic [7:0] PORT_DATA_HI = 8'hC5;
  localparam logic [7:0] PORT_ADDR_LO = 8'hC6;
  localparam logic [7:0] PORT_ADDR_HI = 8'hC7;
  localparam logic [7:0] PORT_CMD     = 8'hC8;

  // Microwire opcodes (sent after the start bit)
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SHORT = 2'b00;

  // Command register bits (write to PORT_CMD)
  localparam int CMD_READ_BIT  = 4;
  localparam int CMD_WRITE_BIT = 5;
  localparam int CMD_SHORT_BIT = 6;

  // Status register bits (read from PORT_CMD)
  localparam int ST_DONE_BIT    = 0;
  localparam int ST_READY_BIT   = 1;
  localparam int ST_TIMEOUT_BIT = 2;

  // x16 organisation
  localparam int DATA_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_OUT,
    ST_SHIFT_IN,
    ST_CS_GAP,
    ST_POLL
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_READ,
    CMD_WRITE,
    CMD_SHORT
  } cmd_t;

  // bits = {short, write, read}; READ beats WRITE beats SHORT
  function automatic cmd_t decode_cmd(input logic [2:0] bits);
    if (bits[0])      return CMD_READ;
    else if (bits[1]) return CMD_WRITE;
    else if (bits[2]) return CMD_SHORT;
    else              return CMD_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bandai2003_eeprom_sk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bandai2003_eeprom_sk                                           |
// | Purpose : Serial-clock divider. Produces EESK with a half-period of      |
// |           CLK_DIV clk cycles plus single-cycle rise/fall strobes that    |
// |           are high in the cycle whose closing edge moves EESK.           |
// | Ports   : clk, rst (sync, active-high), en (run while frame is busy),    |
// |           sk (serial clock), rise / fall (edge strobes)                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bandai2003_eeprom_sk #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sk,
  output logic rise,
  output logic fall
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sk;
  logic          w_tick;

  assign w_tick = en && (r_cnt == LAST);
  assign rise   = w_tick && !r_sk;
  assign fall   = w_tick &&  r_sk;
  assign sk     = r_sk;

  // Idle (en low) holds SK low with the phase counter at zero, so the
  // first rise of a frame always lands CLK_DIV cycles after the start bit.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt <= '0;
      r_sk  <= 1'b0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_sk  <= ~r_sk;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bandai2003_eeprom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bandai2003_eeprom                                              |
// | Purpose : Cartridge Microwire (93LC46-class, x16) EEPROM controller      |
// |           behind console I/O ports C4h-C8h.                              |
// | Ports   : clk, rst       - clock, sync active-high reset                 |
// |           we/addr/wdata  - one-cycle port write                          |
// |           rdata          - combinational port read (00h if unmapped)     |
// |           busy           - frame in progress                             |
// |           eecs/eesk/eedi - Microwire outputs; eedo - Microwire input     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bandai2003_eeprom
  import bandai2003_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int ADDR_BITS    = 6,
  parameter int POLL_TIMEOUT = 65536   // SK periods of EEDO=0 before a write poll gives up
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       eecs,
  output logic       eesk,
  output logic       eedi,
  input  logic       eedo
);

  localparam int            FRAME_W = 3 + ADDR_BITS + DATA_BITS;
  localparam int            BW      = $clog2(FRAME_W + 1);
  localparam int            PW      = $clog2(POLL_TIMEOUT);
  localparam logic [PW-1:0] P_LAST  = PW'(POLL_TIMEOUT - 1);

  state_t              r_state;
  cmd_t                r_cmd;
  logic [15:0]         r_data;
  logic [15:0]         r_addr;
  logic                r_done;
  logic                r_timeout;
  logic                r_busy;
  logic                r_eecs;
  logic                r_eedi;
  logic [FRAME_W-1:0]  r_sr;
  logic [BW-1:0]       r_bits;
  logic [PW-1:0]       r_poll_cnt;
  logic                r_poll_ok;
  logic                r_poll_to;

  cmd_t                w_cmd;
  logic [1:0]          w_op;
  logic [FRAME_W-1:0]  w_frame;
  logic [7:0]          w_status;
  logic                w_rise;
  logic                w_fall;

  bandai2003_eeprom_sk #(.CLK_DIV(CLK_DIV)) u_sk (
    .clk  (clk),
    .rst  (rst),
    .en   (r_busy),
    .sk   (eesk),
    .rise (w_rise),
    .fall (w_fall)
  );

  // Frame image for a command written this cycle: start bit, opcode,
  // address, then data (only meaningful for WRITE).
  always_comb begin
    w_cmd = decode_cmd(wdata[CMD_SHORT_BIT:CMD_READ_BIT]);
    case (w_cmd)
      CMD_READ:  w_op = OP_READ;
      CMD_WRITE: w_op = OP_WRITE;
      default:   w_op = OP_SHORT;
    endcase
    w_frame = {1'b1, w_op, r_addr[ADDR_BITS-1:0],
               (w_cmd == CMD_WRITE) ? r_data : 16'h0000};
  end

  always_comb begin
    w_status                 = 8'h00;
    w_status[ST_DONE_BIT]    = r_done;
    w_status[ST_READY_BIT]   = ~r_busy;
    w_status[ST_TIMEOUT_BIT] = r_timeout;
  end

  always_comb begin
    rdata = 8'h00;
    case (addr)
      PORT_DATA_LO: rdata = r_data[7:0];
      PORT_DATA_HI: rdata = r_data[15:8];
      PORT_ADDR_LO: rdata = r_addr[7:0];
      PORT_ADDR_HI: rdata = r_addr[15:8];
      PORT_CMD:     rdata = w_status;
      default:      rdata = 8'h00;
    endcase
  end

  assign busy = r_busy;
  assign eecs = r_eecs;
  assign eedi = r_eedi;

  // Every frame ends on an SK fall strobe, so EESK drops on the same edge
  // that clears BUSY/EECS/EEDI. Port writes are only honoured in IDLE,
  // which also makes a write coinciding with frame completion a no-op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cmd      <= CMD_NONE;
      r_data     <= 16'h0000;
      r_addr     <= 16'h0000;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
      r_eecs     <= 1'b0;
      r_eedi     <= 1'b0;
      r_sr       <= '0;
      r_bits     <= '0;
      r_poll_cnt <= '0;
      r_poll_ok  <= 1'b0;
      r_poll_to  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (we) begin
            case (addr)
              PORT_DATA_LO: r_data[7:0]  <= wdata;
              PORT_DATA_HI: r_data[15:8] <= wdata;
              PORT_ADDR_LO: r_addr[7:0]  <= wdata;
              PORT_ADDR_HI: r_addr[15:8] <= wdata;
              PORT_CMD: begin
                if (w_cmd != CMD_NONE) begin
                  r_cmd     <= w_cmd;
                  r_done    <= 1'b0;
                  r_timeout <= 1'b0;
                  r_busy    <= 1'b1;
                  r_eecs    <= 1'b1;
                  r_eedi    <= w_frame[FRAME_W-1];
                  r_sr      <= w_frame << 1;
                  // bits still to present after the start bit
                  r_bits    <= (w_cmd == CMD_WRITE) ? BW'(FRAME_W - 1)
                                                    : BW'(ADDR_BITS + 2);
                  r_state   <= ST_SHIFT_OUT;
                end
              end
              default: ;
            endcase
          end
        end

        ST_SHIFT_OUT: begin
          if (w_fall) begin
            if (r_bits != '0) begin
              r_eedi <= r_sr[FRAME_W-1];
              r_sr   <= r_sr << 1;
              r_bits <= r_bits - BW'(1);
            end else begin
              r_eedi <= 1'b0;
              case (r_cmd)
                CMD_READ: begin
                  r_bits  <= BW'(DATA_BITS - 1);
                  r_state <= ST_SHIFT_IN;
                end
                CMD_WRITE: begin
                  r_eecs  <= 1'b0;
                  r_state <= ST_CS_GAP;
                end
                default: begin
                  r_busy  <= 1'b0;
                  r_eecs  <= 1'b0;
                  r_state <= ST_IDLE;
                end
              endcase
            end
          end
        end

        ST_SHIFT_IN: begin
          if (w_rise)
            r_data <= {r_data[14:0], eedo};
          if (w_fall) begin
            if (r_bits == '0) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_eecs  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_bits <= r_bits - BW'(1);
            end
          end
        end

        // One full SK period with CS low starts the self-timed write.
        ST_CS_GAP: begin
          if (w_fall) begin
            r_eecs     <= 1'b1;
            r_poll_cnt <= '0;
            r_poll_ok  <= 1'b0;
            r_poll_to  <= 1'b0;
            r_state    <= ST_POLL;
          end
        end

        // Sample ready on each SK rise; leave on the following fall.
        ST_POLL: begin
          if (w_rise) begin
            if (eedo)
              r_poll_ok <= 1'b1;
            else if (r_poll_cnt == P_LAST)
              r_poll_to <= 1'b1;
            else
              r_poll_cnt <= r_poll_cnt + PW'(1);
          end
          if (w_fall && (r_poll_ok || r_poll_to)) begin
            r_timeout <= r_poll_to && !r_poll_ok;
            r_busy    <= 1'b0;
            r_eecs    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_eecs  <= 1'b0;
          r_eedi  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bandai2003_eeprom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_bandai2003_eeprom                                           |
// | Purpose : Directed self-checking bench for bandai2003_eeprom with a      |
// |           small behavioural 93LC46 (x16) model on the Microwire pins.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bandai2003_eeprom;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       eecs;
  logic       eesk;
  logic       eedi;
  logic       eedo = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int gap_cnt  = 0;
  int dur;
  int t0;
  int m_ready_after;

  // POLL_TIMEOUT shortened so the timeout path fits a short run
  bandai2003_eeprom #(
    .CLK_DIV      (4),
    .ADDR_BITS    (6),
    .POLL_TIMEOUT (64)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .busy  (busy),
    .eecs  (eecs),
    .eesk  (eesk),
    .eedi  (eedi),
    .eedo  (eedo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we && addr == 8'hC8)    gap_cnt <= 0;
    else if (busy && !eecs)     gap_cnt <= gap_cnt + 1;
  end

  // ---------------- EEPROM model (edges detected on clk) ----------------
  logic        p_sk = 1'b0, p_cs = 1'b0;
  logic [24:0] m_sh = '0;
  int          m_cnt = 0, m_pcnt = 0;
  logic [15:0] m_rd = '0;
  logic        m_reading = 1'b0, m_poll = 1'b0, m_wpend = 1'b0;
  logic        m_wen = 1'b0, m_loaded = 1'b0;
  logic [15:0] mem [0:63];

  always @(posedge clk) begin
    p_sk <= eesk;
    p_cs <= eecs;
    if (!m_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
      mem[6'h15] <= 16'hBEEF;
      m_loaded   <= 1'b1;
    end
    if (eecs && !p_cs) begin
      if (m_wpend) begin
        m_poll <= 1'b1; m_pcnt <= 0; eedo <= 1'b0;
      end else begin
        m_cnt <= 0; m_sh <= '0;
      end
    end else if (!eecs && p_cs) begin
      eedo      <= 1'b0;
      m_reading <= 1'b0;
      if (m_poll) begin
        m_poll <= 1'b0; m_wpend <= 1'b0;
      end else if (m_cnt == 25 && m_sh[24:22] == 3'b101) begin
        if (m_wen) begin
          mem[m_sh[21:16]] <= m_sh[15:0];
          m_wpend          <= 1'b1;
        end
      end else if (m_cnt == 9 && m_sh[8:6] == 3'b100) begin
        if (m_sh[5:4] == 2'b11)      m_wen <= 1'b1;
        else if (m_sh[5:4] == 2'b00) m_wen <= 1'b0;
      end
    end else if (eecs && eesk && !p_sk) begin
      if (m_poll) begin
        m_pcnt <= m_pcnt + 1;
        if (m_pcnt + 1 >= m_ready_after) eedo <= 1'b1;
      end else begin
        m_sh  <= {m_sh[23:0], eedi};
        m_cnt <= m_cnt + 1;
        if (m_cnt == 8 && m_sh[7:5] == 3'b110) begin
          m_rd      <= mem[{m_sh[4:0], eedi}];
          m_reading <= 1'b1;
          eedo      <= 1'b0;   // dummy zero
        end
      end
    end else if (eecs && !eesk && p_sk && m_reading) begin
      eedo <= m_rd[15];
      m_rd <= {m_rd[14:0], 1'b0};
    end
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0; addr = 8'h00;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check_eq(tag, {24'h0, rdata}, {24'h0, exp});
  endtask

  task automatic wait_idle(input int start, input int limit, output int d);
    while (busy && (cyc - start) < limit) @(negedge clk);
    d = cyc - start;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we = 1'b0; addr = 8'h00; wdata = 8'h00; m_ready_after = 5;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    rd_chk("rst_status", 8'hC8, 8'h02);
    rd_chk("rst_c4", 8'hC4, 8'h00);
    rd_chk("rst_c5", 8'hC5, 8'h00);
    rd_chk("rst_c6", 8'hC6, 8'h00);
    rd_chk("rst_c7", 8'hC7, 8'h00);
    rd_chk("unmapped", 8'h10, 8'h00);
    check_eq("rst_pins", {busy, eecs, eesk, eedi}, 4'b0000);

    // READ word 15h
    bus_wr(8'hC6, 8'h15);
    bus_wr(8'hC8, 8'h10);
    check_eq("rd_start", {busy, eecs, eedi}, 3'b111);
    t0 = cyc;
    wait_idle(t0, 1000, dur);
    check_eq("rd_busy_cycles", dur, 200);
    check_eq("rd_end_pins", {eecs, eesk, eedi}, 3'b000);
    check_eq("rd_di_stream", m_sh[24:16], 9'h195);
    rd_chk("rd_c4", 8'hC4, 8'hEF);
    rd_chk("rd_c5", 8'hC5, 8'hBE);
    rd_chk("rd_status", 8'hC8, 8'h03);

    // SHORT EWEN
    bus_wr(8'hC6, 8'h30);
    bus_wr(8'hC8, 8'h40);
    t0 = cyc;
    wait_idle(t0, 1000, dur);
    check_eq("ewen_busy_cycles", dur, 72);
    repeat (2) @(negedge clk);
    check_eq("ewen_bits", m_cnt, 9);
    check_eq("ewen_stream", m_sh[8:0], 9'h130);
    check_eq("ewen_model_wen", m_wen, 1'b1);
    rd_chk("ewen_status", 8'hC8, 8'h02);

    // WRITE 1234h to word 03h, with writes attempted while busy
    bus_wr(8'hC4, 8'h34);
    bus_wr(8'hC5, 8'h12);
    bus_wr(8'hC6, 8'h03);
    bus_wr(8'hC8, 8'h20);
    t0 = cyc;
    bus_wr(8'hC6, 8'h55);
    bus_wr(8'hC8, 8'h10);
    wait_idle(t0, 2000, dur);
    check_eq("wr_busy_cycles", dur, 256);
    check_eq("wr_cs_gap", gap_cnt, 8);
    repeat (2) @(negedge clk);
    check_eq("wr_bits", m_cnt, 25);
    check_eq("wr_stream", m_sh, 25'h1431234);
    check_eq("wr_mem", mem[3], 16'h1234);
    rd_chk("wr_addr_kept", 8'hC6, 8'h03);
    rd_chk("wr_c4", 8'hC4, 8'h34);
    rd_chk("wr_status", 8'hC8, 8'h02);

    // Read word 03h back; port write on the completion cycle is ignored
    bus_wr(8'hC4, 8'h00);
    bus_wr(8'hC5, 8'h00);
    bus_wr(8'hC8, 8'h10);
    repeat (199) @(negedge clk);
    check_eq("rd2_busy_last", busy, 1'b1);
    we = 1'b1; addr = 8'hC6; wdata = 8'h77;
    @(negedge clk);
    we = 1'b0;
    check_eq("rd2_busy_end", busy, 1'b0);
    rd_chk("rd2_addr_kept", 8'hC6, 8'h03);
    rd_chk("rd2_c4", 8'hC4, 8'h34);
    rd_chk("rd2_c5", 8'hC5, 8'h12);
    rd_chk("rd2_status", 8'hC8, 8'h03);

    // RST mid-READ
    bus_wr(8'hC8, 8'h10);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_pins", {busy, eecs, eesk, eedi}, 4'b0000);
    rd_chk("rst_mid_status", 8'hC8, 8'h02);
    rd_chk("rst_mid_addr", 8'hC6, 8'h00);
    rd_chk("rst_mid_data", 8'hC5, 8'h00);

    // WRITE with EEDO never ready -> timeout
    m_ready_after = 1 << 30;
    bus_wr(8'hC4, 8'hCD);
    bus_wr(8'hC5, 8'hAB);
    bus_wr(8'hC6, 8'h07);
    bus_wr(8'hC8, 8'h20);
    t0 = cyc;
    wait_idle(t0, 3000, dur);
    check_eq("to_busy_cycles", dur, 720);
    check_eq("to_pins", {eecs, eesk, eedi}, 3'b000);
    rd_chk("to_status", 8'hC8, 8'h06);

    // No command bit set: no-op, status untouched
    bus_wr(8'hC8, 8'h81);
    check_eq("noop_busy", busy, 1'b0);
    rd_chk("noop_status", 8'hC8, 8'h06);

    // SHORT EWDS clears TIMEOUT and write-disables the model
    bus_wr(8'hC6, 8'h00);
    bus_wr(8'hC8, 8'h40);
    t0 = cyc;
    wait_idle(t0, 1000, dur);
    check_eq("ewds_busy_cycles", dur, 72);
    rd_chk("ewds_status", 8'hC8, 8'h02);
    repeat (2) @(negedge clk);
    check_eq("ewds_model_wen", m_wen, 1'b0);

    // READ+WRITE bits together: READ wins
    bus_wr(8'hC6, 8'h03);
    bus_wr(8'hC8, 8'h30);
    t0 = cyc;
    wait_idle(t0, 1000, dur);
    check_eq("prio_busy_cycles", dur, 200);
    rd_chk("prio_c5", 8'hC5, 8'h12);
    rd_chk("prio_c4", 8'hC4, 8'h34);
    rd_chk("prio_status", 8'hC8, 8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bandai2003_eeprom.md
# bandai2003_eeprom

Cartridge serial-EEPROM controller sitting downstream of the mapper's I/O-port decode on the console bus. It decodes ports C4h–C8h, holds the data, address and command/status registers, and runs Microwire (93LC46-class, x16) frames on EECS/EESK/EEDI/EEDO. Save-game reads and writes issued by the console through these ports become serial transactions to the on-cart EEPROM.

## Interface
- CLK_DIV, 4: CLK cycles per EESK half-period (≥2).
- ADDR_BITS, 6: EEPROM word-address width (6 for 93LC46, 10 for 93C86).
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- WE  in  1  one-cycle register write strobe.
- ADDR  in  8  I/O port number.
- WDATA  in  8  write data.
- RDATA  out  8  read data, combinational from ADDR; 00h for unmapped ports.
- BUSY  out  1  frame in progress.
- EECS  out  1  EEPROM chip select, active-high.
- EESK  out  1  EEPROM serial clock.
- EEDI  out  1  serial data to EEPROM.
- EEDO  in  1  serial data / ready from EEPROM.

## Operation
- Ports: C4h data[7:0], C5h data[15:8], C6h addr[7:0], C7h addr[15:8], C8h command (write) / status (read).
- Status read: bit0 DONE (read data valid), bit1 READY (= ~BUSY), bit2 TIMEOUT; other bits 0.
- Command write C8h: bit4 READ, bit5 WRITE, bit6 SHORT. Priority READ > WRITE > SHORT; no bit set → no-op, no status change.
- Writes to C4h–C8h while BUSY are ignored.
- Accepting a command clears DONE and TIMEOUT.
- Frame always begins: start bit 1, 2-bit opcode, ADDR_BITS address bits (MSB first from addr[ADDR_BITS-1:0]).
- READ: opcode 10; then 16 bits shifted in MSB first into data register (dummy 0 bit discarded as part of the address phase); sets DONE.
- WRITE: opcode 01; then data[15:0] out MSB first; EECS low one SK period (CS_GAP); EECS high; poll EEDO each SK rising edge until 1; then EECS low, end.
- SHORT: opcode 00; address field sent verbatim (top two address bits select EWEN 11 / ERAL 10 / WRAL 01 / EWDS 00); no data phase.
- States: IDLE → SHIFT_OUT → (SHIFT_IN | CS_GAP → POLL | END) → IDLE. Bit counter sized for ADDR_BITS+3+16.
- POLL timeout: 65536 SK periods without EEDO=1 → TIMEOUT=1, frame aborted, IDLE.

## Timing
- Reset values: EECS 0, EESK 0, EEDI 0, BUSY 0; data 0000h, addr 0000h; DONE 0, READY 1, TIMEOUT 0.
- Command accepted at cycle T: BUSY=1, EECS=1 and EEDI=start bit from T+1.
- EESK idles low; rises CLK_DIV cycles after each bit is presented; EEDI changes only after EESK falling edges; EEDO sampled on the CLK in which EESK rises.
- READ latency (defaults): 9 bits out + 16 in = 25 SK periods = 200 cycles; BUSY and EECS fall at T+201, DONE=1 same cycle.
- End of frame: EESK low, EECS low, EEDI 0 in the same cycle BUSY falls.
- RST mid-frame: next cycle all outputs at reset values, state IDLE, registers at reset values.
- WE simultaneous with frame completion: frame completion wins; write ignored.

## Structure
- Package bandai2003_pkg: port addresses C4h–C8h, opcodes, command/status bit positions, state enum.
- Sub-module bandai2003_eeprom_sk: divider producing EESK plus one-cycle rise/fall strobes, enabled only while BUSY, cleared on RST.

## Test plan
- Reset then read C8h → 02h; C4h–C7h → 00h; EECS/EESK/EEDI low.
- addr=15h, READ, EEPROM model holds word 15h=BEEFh → DI stream 1,10,010101; BUSY high 200 cycles; C4h=EFh, C5h=BEh, C8h=03h.
- addr=03h, data=1234h, WRITE, model ready after 5 SK → 25 bits out, CS gap one SK period, BUSY falls after EEDO=1; model word 03h=1234h.
- SHORT with addr=30h → 9-bit frame 1,00,110000 (EWEN), no data phase; model write-enabled.
- WRITE while BUSY, and write C6h while BUSY → ignored; addr unchanged; RST mid-READ → next cycle EECS=0, C8h=02h.
- WRITE with EEDO held 0 → after 65536 SK periods BUSY=0, C8h=06h.
